// File: rtl/pmod_debounce.sv
// Per-bit synchroniser and debouncer for active-low PMOD buttons/switches feeding the adder.
// Define PMOD_PRESS_PULSE_EN to add the per-bit 'press' pulse output on 1->0 transitions.
module pmod_debounce #(
   parameter int WIDTH           = 3,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pmod_raw,
   output logic [WIDTH-1:0] pmod_db,
   output logic             changed
`ifdef PMOD_PRESS_PULSE_EN
   ,
   output logic [WIDTH-1:0] press
`endif
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0][SYNC_STAGES-1:0] sync_q;
   logic [WIDTH-1:0]                  s;
   logic [WIDTH-1:0][CW-1:0]          cnt_q;
   logic [WIDTH-1:0][CW-1:0]          cnt_d;
   logic [WIDTH-1:0]                  db_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pmod_raw[i]};
         end
      end
   end

   always_comb begin
      s = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         s[i] = sync_q[i][SYNC_STAGES-1];
      end
   end

   // A match or an acceptance both return the count to zero, so the counter never exceeds CNT_LAST.
   always_comb begin
      db_d  = pmod_db;
      cnt_d = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (s[i] != pmod_db[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               db_d[i] = s[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         pmod_db <= '1;
         changed <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pmod_db <= db_d;
         changed <= |(db_d ^ pmod_db);
      end
   end

`ifdef PMOD_PRESS_PULSE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         press <= '0;
      end else begin
         press <= pmod_db & ~db_d;
      end
   end
`endif

endmodule

// File: tb/tb_pmod_debounce.sv
// Bench for pmod_debounce (SYNC_STAGES=2, DEBOUNCE_CYCLES=4): directed cases with literal
// expectations plus randomized hold lengths, all checked against a sample-window model.
module tb_pmod_debounce;

   localparam int W  = 3;
   localparam int S  = 2;
   localparam int D  = 4;
   localparam int HD = S + D - 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] pmod_raw = '0;
   logic [W-1:0] pmod_db;
   logic         changed;
`ifdef PMOD_PRESS_PULSE_EN
   logic [W-1:0] press;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pmod_debounce #(
      .WIDTH(W),
      .SYNC_STAGES(S),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pmod_raw(pmod_raw),
      .pmod_db(pmod_db),
      .changed(changed)
`ifdef PMOD_PRESS_PULSE_EN
      ,
      .press(press)
`endif
   );

   // Model: h[k] is the raw level sampled k+1 edges ago. The synchronised level seen at an edge
   // is h[S-1]; a bit flips when the last D synchronised samples all disagree with its output.
   bit [HD-1:0][W-1:0] h;
   bit [W-1:0]         m_db;
   bit                 m_chg;
   bit [W-1:0]         m_press;
   bit                 m_valid = 1'b0;

   function automatic bit [W-1:0] accept(input bit [HD-1:0][W-1:0] hh, input bit [W-1:0] db);
      bit [W-1:0] r;
      bit         all;
      r = db;
      for (int i = 0; i < W; i++) begin
         all = 1'b1;
         for (int j = 0; j < D; j++) begin
            if (hh[S-1+j][i] == db[i]) all = 1'b0;
         end
         if (all) r[i] = ~db[i];
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         h       <= '1;
         m_db    <= '1;
         m_chg   <= 1'b0;
         m_press <= '0;
         m_valid <= 1'b1;
      end else begin
         m_db    <= accept(h, m_db);
         m_chg   <= (accept(h, m_db) != m_db);
         m_press <= m_db & ~accept(h, m_db);
         h       <= {h[HD-2:0], pmod_raw};
      end
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Advance one edge, then compare every output against the model.
   task automatic tick();
      @(posedge clk);
      #1;
      if (m_valid) begin
         chk("model_db", pmod_db, m_db);
         chk("model_changed", {2'b00, changed}, {2'b00, m_chg});
`ifdef PMOD_PRESS_PULSE_EN
         chk("model_press", press, m_press);
`endif
      end
   endtask

   int pulses;
   int hold [W];
   logic [W-1:0] lvl;

   initial begin
      // Reset with all pins low: nothing may propagate during reset.
      rst = 1'b1;
      pmod_raw = 3'b000;
      tick();
      chk("reset_db", pmod_db, 3'b111);
      chk("reset_changed", {2'b00, changed}, 3'b000);
      rst = 1'b0;
      pmod_raw = 3'b111;
      repeat (8) tick();
      chk("idle_db", pmod_db, 3'b111);

      // Clean press of bit 0.
      pmod_raw = 3'b110;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e == 5) chk("press_early_db", pmod_db, 3'b111);
         if (e == 6) begin
            chk("press_db", pmod_db, 3'b110);
            chk("press_changed", {2'b00, changed}, 3'b001);
`ifdef PMOD_PRESS_PULSE_EN
            chk("press_pulse", press, 3'b001);
`endif
         end
         if (e == 7) chk("press_changed_off", {2'b00, changed}, 3'b000);
      end
      pmod_raw = 3'b111;
      repeat (8) tick();

      // Three-cycle glitch on bit 1 is rejected.
      pulses = 0;
      pmod_raw = 3'b101;
      for (int e = 1; e <= 12; e++) begin
         tick();
         if (e == 3) pmod_raw = 3'b111;
         pulses += int'(changed);
      end
      chk("glitch_db", pmod_db, 3'b111);
      chk("glitch_pulses", W'(pulses), 3'd0);

      // Four-cycle low on bit 1 is accepted, then released.
      pulses = 0;
      pmod_raw = 3'b101;
      for (int e = 1; e <= 12; e++) begin
         tick();
         if (e == 4) pmod_raw = 3'b111;
         if (e == 6) chk("min_low_db", pmod_db, 3'b101);
         if (e == 9) chk("min_low_held", pmod_db, 3'b101);
         if (e == 10) chk("min_low_release", pmod_db, 3'b111);
         pulses += int'(changed);
      end
      chk("min_low_pulses", W'(pulses), 3'd2);

      // Bounce on bit 2: low 2, high 1, low 6.
      pulses = 0;
      pmod_raw = 3'b011;
      for (int e = 1; e <= 18; e++) begin
         tick();
         if (e == 2) pmod_raw = 3'b111;
         if (e == 3) pmod_raw = 3'b011;
         if (e == 9) pmod_raw = 3'b111;
         if (e == 8) chk("bounce_early_db", pmod_db, 3'b111);
         if (e == 9) chk("bounce_db", pmod_db, 3'b011);
         if (e <= 12) pulses += int'(changed);
      end
      chk("bounce_pulses", W'(pulses), 3'd1);
      chk("bounce_release_db", pmod_db, 3'b111);

      // All bits pressed, then released, on the same edge.
      pmod_raw = 3'b000;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e == 5) chk("all_early_db", pmod_db, 3'b111);
         if (e == 6) begin
            chk("all_db", pmod_db, 3'b000);
            chk("all_changed", {2'b00, changed}, 3'b001);
`ifdef PMOD_PRESS_PULSE_EN
            chk("all_press", press, 3'b111);
`endif
         end
         if (e == 7) chk("all_changed_off", {2'b00, changed}, 3'b000);
      end
      pmod_raw = 3'b111;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e == 6) begin
            chk("rel_db", pmod_db, 3'b111);
            chk("rel_changed", {2'b00, changed}, 3'b001);
`ifdef PMOD_PRESS_PULSE_EN
            chk("rel_press", press, 3'b000);
`endif
         end
      end

      // Reset in the middle of a count.
      pmod_raw = 3'b110;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("midrst_db", pmod_db, 3'b111);
      rst = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick();
         if (e == 5) chk("midrst_early_db", pmod_db, 3'b111);
         if (e == 6) chk("midrst_db_update", pmod_db, 3'b110);
      end
      pmod_raw = 3'b111;
      repeat (8) tick();

      // Random hold lengths straddling the acceptance threshold, with occasional resets.
      lvl = 3'b111;
      for (int i = 0; i < W; i++) hold[i] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < W; i++) begin
            if (hold[i] == 0) begin
               lvl[i] = 1'($urandom_range(0, 1));
               hold[i] = int'($urandom_range(1, 7));
            end
            hold[i]--;
         end
         pmod_raw = lvl;
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
